// File: rtl/jtvigil_rom_pkg.sv
// Shared types and address/data helpers for the two-slot ROM reader.
// Word addresses count 16-bit SDRAM words.
package jtvigil_rom_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

   // Slot address -> 16-bit word address (before the bank offset is added).
   function automatic logic [21:0] sdram_word_addr(input logic [31:0] addr, input int dw);
      logic [21:0] w;
      case (dw)
         8:       w = 22'(addr >> 1);
         16:      w = 22'(addr);
         default: w = 22'(addr << 1);
      endcase
      return w;
   endfunction

   // Reduce a cached 32-bit entry to slot width; lsb picks the byte for 8-bit slots.
   function automatic logic [31:0] byte_select(input logic [31:0] data, input logic lsb, input int dw);
      logic [31:0] d;
      case (dw)
         8:       d = {24'd0, lsb ? data[15:8] : data[7:0]};
         16:      d = {16'd0, data[15:0]};
         default: d = data;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/jtvigil_rom_cache_entry.sv
// One-entry read cache for a ROM slot: tag/valid/data storage, hit detect,
// and the registered ok/dout pair seen by the client.
module jtvigil_rom_cache_entry
   import jtvigil_rom_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          fill,
   input  logic [AW-1:0] fill_tag,
   input  logic [31:0]   fill_data,
   output logic [DW-1:0] dout,
   output logic          ok,
   output logic          miss
);

   logic          valid;
   logic [AW-1:0] tag;
   logic [31:0]   data;
   logic [31:0]   sel;
   logic          hit;

   // The full slot address is the tag, so byte lanes of one word are distinct entries.
   assign hit  = cs & valid & (tag == addr);
   assign miss = cs & ~hit;
   assign sel  = byte_select(data, addr[0], DW);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
         ok    <= 1'b0;
         dout  <= '0;
      end else begin
         if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
         end
         ok <= hit;
         if (hit) dout <= DW'(sel);
      end
   end

endmodule

// File: rtl/jtvigil_rom_2slot_arb.sv
// Two-client ROM reader for one SDRAM bank: per-slot cache, round-robin miss
// arbitration, single-request SDRAM read and 16-bit word assembly.
module jtvigil_rom_2slot_arb
   import jtvigil_rom_pkg::*;
#(
   parameter int          SLOT0_DW     = 8,
   parameter int          SLOT0_AW     = 16,
   parameter int          SLOT1_DW     = 8,
   parameter int          SLOT1_AW     = 16,
   parameter logic [21:0] SLOT0_OFFSET = 22'd0,
   parameter logic [21:0] SLOT1_OFFSET = 22'd0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                slot0_cs,
   input  logic [SLOT0_AW-1:0] slot0_addr,
   output logic [SLOT0_DW-1:0] slot0_dout,
   output logic                slot0_ok,
   input  logic                slot1_cs,
   input  logic [SLOT1_AW-1:0] slot1_addr,
   output logic [SLOT1_DW-1:0] slot1_dout,
   output logic                slot1_ok,
   output logic                sdram_req,
   output logic [21:0]         sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_dst,
   input  logic                data_rdy,
   input  logic [15:0]         data_read
);

   state_t      state, state_nx;
   logic        miss0, miss1;
   logic        ptr, slot, grant, issue, fill;
   logic [21:0] waddr0, waddr1;
   logic [31:0] tag_l;
   logic [15:0] w0, w1, w0_nx, w1_nx;
   logic        wcnt;

   assign waddr0 = sdram_word_addr(32'(slot0_addr), SLOT0_DW) + SLOT0_OFFSET;
   assign waddr1 = sdram_word_addr(32'(slot1_addr), SLOT1_DW) + SLOT1_OFFSET;

   // Fill data includes a word arriving in the same cycle as data_rdy.
   assign w0_nx = (data_dst && !wcnt) ? data_read : w0;
   assign w1_nx = (data_dst &&  wcnt) ? data_read : w1;

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      fill     = 1'b0;
      grant    = ptr;
      case (state)
         IDLE: if (miss0 || miss1) begin
            issue    = 1'b1;
            grant    = (miss0 && miss1) ? ptr : miss1;
            state_nx = REQ;
         end
         REQ:  if (sdram_ack) state_nx = WAIT;
         WAIT: if (data_rdy) begin
            fill     = 1'b1;
            state_nx = FILL;
         end
         FILL: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         slot       <= 1'b0;
         tag_l      <= '0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         w0         <= '0;
         w1         <= '0;
         wcnt       <= 1'b0;
      end else begin
         state <= state_nx;
         if (issue) begin
            slot       <= grant;
            ptr        <= ~grant;
            tag_l      <= grant ? 32'(slot1_addr) : 32'(slot0_addr);
            sdram_req  <= 1'b1;
            sdram_addr <= grant ? waddr1 : waddr0;
            w0         <= '0;
            w1         <= '0;
            wcnt       <= 1'b0;
         end
         if (state == REQ && sdram_ack) sdram_req <= 1'b0;
         if (state == WAIT && data_dst) begin
            w0   <= w0_nx;
            w1   <= w1_nx;
            wcnt <= 1'b1;
         end
      end
   end

   jtvigil_rom_cache_entry #(.DW(SLOT0_DW), .AW(SLOT0_AW)) u_entry0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs        (slot0_cs),
      .addr      (slot0_addr),
      .fill      (fill & ~slot),
      .fill_tag  (SLOT0_AW'(tag_l)),
      .fill_data ({w1_nx, w0_nx}),
      .dout      (slot0_dout),
      .ok        (slot0_ok),
      .miss      (miss0)
   );

   jtvigil_rom_cache_entry #(.DW(SLOT1_DW), .AW(SLOT1_AW)) u_entry1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs        (slot1_cs),
      .addr      (slot1_addr),
      .fill      (fill & slot),
      .fill_tag  (SLOT1_AW'(tag_l)),
      .fill_data ({w1_nx, w0_nx}),
      .dout      (slot1_dout),
      .ok        (slot1_ok),
      .miss      (miss1)
   );

endmodule

// File: tb/tb_jtvigil_rom_2slot_arb.sv
// Bench for the two-slot ROM reader: slot 0 is 8-bit, slot 1 is 32-bit with a
// bank offset; a reference SDRAM content function gives expected read data.
module tb_jtvigil_rom_2slot_arb;

   localparam logic [21:0] OFF1 = 22'h8000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs0, cs1;
   logic [15:0] addr0;
   logic [17:0] addr1;
   logic [7:0]  dout0;
   logic [31:0] dout1;
   logic        ok0, ok1;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack, data_dst, data_rdy;
   logic [15:0] data_read;

   // manual (m_) and automatic responder (r_) drivers are merged here
   logic        m_ack, m_dst, m_rdy, r_ack, r_dst, r_rdy;
   logic [15:0] m_read, r_read;
   assign sdram_ack = m_ack | r_ack;
   assign data_dst  = m_dst | r_dst;
   assign data_rdy  = m_rdy | r_rdy;
   assign data_read = r_dst ? r_read : m_read;

   int          n_tests = 0;
   int          n_fail = 0;
   bit          resp_en = 1'b0;
   int          unstable = 0;
   logic [21:0] req_log[$];
   logic [21:0] resp_a;

   jtvigil_rom_2slot_arb #(
      .SLOT0_DW(8), .SLOT0_AW(16), .SLOT1_DW(32), .SLOT1_AW(18),
      .SLOT0_OFFSET(22'd0), .SLOT1_OFFSET(OFF1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .slot0_cs(cs0), .slot0_addr(addr0), .slot0_dout(dout0), .slot0_ok(ok0),
      .slot1_cs(cs1), .slot1_addr(addr1), .slot1_dout(dout1), .slot1_ok(ok1),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
      .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
   );

   always #5 clk = ~clk;

   // Reference SDRAM content and slot address/data mapping.
   function automatic logic [15:0] mem(input logic [21:0] a);
      logic [21:0] t;
      t = a * 22'd40503;
      return t[15:0] ^ {a[5:0], a[21:12]};
   endfunction
   function automatic logic [21:0] wa0(input logic [15:0] a);
      return 22'(a / 2);
   endfunction
   function automatic logic [21:0] wa1(input logic [17:0] a);
      return 22'(a) * 22'd2 + OFF1;
   endfunction
   function automatic logic [7:0] exp0(input logic [15:0] a);
      logic [15:0] w;
      w = mem(wa0(a));
      return (a % 2 == 1) ? w[15:8] : w[7:0];
   endfunction
   function automatic logic [31:0] exp1(input logic [17:0] a);
      return {mem(wa1(a) + 22'd1), mem(wa1(a))};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   // Manual SDRAM side: ack, then one or two words with rdy on the last.
   task automatic serve(input logic [15:0] wa, input logic [15:0] wb, input bit two);
      m_ack = 1'b1; tick(); m_ack = 1'b0; tick();
      m_dst = 1'b1; m_read = wa; m_rdy = !two; tick();
      if (two) begin
         m_read = wb; m_rdy = 1'b1; tick();
      end
      m_dst = 1'b0; m_rdy = 1'b0;
   endtask

   // Automatic SDRAM responder: random ack delay and latency, two-word burst.
   initial begin
      r_ack = 1'b0; r_dst = 1'b0; r_rdy = 1'b0; r_read = '0;
      forever begin
         tick();
         if (resp_en && sdram_req) begin
            resp_a = sdram_addr;
            req_log.push_back(resp_a);
            repeat ($urandom_range(0, 3)) begin
               tick();
               if (!sdram_req || sdram_addr !== resp_a) unstable++;
            end
            r_ack = 1'b1; tick(); r_ack = 1'b0;
            repeat ($urandom_range(0, 4)) tick();
            r_dst = 1'b1; r_read = mem(resp_a); tick();
            r_read = mem(resp_a + 22'd1); r_rdy = 1'b1; tick();
            r_dst = 1'b0; r_rdy = 1'b0;
         end
      end
   end

   task automatic test_reset();
      resp_en = 1'b0; rst_n = 1'b0;
      cs0 = 1'b1; cs1 = 1'b1; addr0 = 16'h0; addr1 = 18'h0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if ({sdram_req, ok0, ok1} !== 3'b000 || sdram_addr !== 22'd0 || dout0 !== 8'd0 || dout1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state req=%b ok0=%b ok1=%b addr=%h d0=%h d1=%h required all 0",
                     sdram_req, ok0, ok1, sdram_addr, dout0, dout1);
         end
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (sdram_req !== 1'b1 || sdram_addr !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_release_req req=%b addr=%h required 1 000000", sdram_req, sdram_addr);
      end
   endtask

   task automatic test_byte_slot();
      do_reset();
      cs0 = 1'b1; addr0 = 16'h0005;
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      n_tests++;
      if (sdram_req !== 1'b1 || sdram_addr !== 22'h2) begin
         n_fail++;
         $display("FAIL byte_issue req=%b addr=%h required 1 000002", sdram_req, sdram_addr);
      end
      serve(16'hA55A, 16'h0, 1'b0);
      n_tests++;
      if (ok0 !== 1'b0) begin
         n_fail++; $display("FAIL byte_ok_early ok0=%b required 0", ok0);
      end
      tick();
      n_tests++;
      if (ok0 !== 1'b1 || dout0 !== 8'hA5) begin
         n_fail++; $display("FAIL byte_hi ok0=%b dout0=%h required 1 a5", ok0, dout0);
      end
      // other byte of the same word is a separate tag
      addr0 = 16'h0004;
      tick();
      n_tests++;
      if (ok0 !== 1'b0 || sdram_req !== 1'b1 || sdram_addr !== 22'h2) begin
         n_fail++;
         $display("FAIL byte_lsb_miss ok0=%b req=%b addr=%h required 0 1 000002", ok0, sdram_req, sdram_addr);
      end
      serve(16'hA55A, 16'h0, 1'b0);
      tick();
      n_tests++;
      if (ok0 !== 1'b1 || dout0 !== 8'h5A) begin
         n_fail++; $display("FAIL byte_lo ok0=%b dout0=%h required 1 5a", ok0, dout0);
      end
   endtask

   task automatic test_word32_slot();
      do_reset();
      cs1 = 1'b1; addr1 = 18'h10;
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      n_tests++;
      if (sdram_req !== 1'b1 || sdram_addr !== 22'h8020) begin
         n_fail++; $display("FAIL w32_issue req=%b addr=%h required 1 008020", sdram_req, sdram_addr);
      end
      serve(16'h1234, 16'h5678, 1'b1);
      tick();
      n_tests++;
      if (ok1 !== 1'b1 || dout1 !== 32'h5678_1234) begin
         n_fail++; $display("FAIL w32_data ok1=%b dout1=%h required 1 56781234", ok1, dout1);
      end
   endtask

   task automatic test_arbitration();
      logic [15:0] a0, b0;
      logic [17:0] a1, b1;
      logic [21:0] exp_log[4];
      do_reset();
      resp_en = 1'b1; unstable = 0; req_log.delete();
      a0 = 16'($urandom); a1 = 18'($urandom);
      b0 = a0 ^ 16'($urandom_range(1, 16'hFFFF));
      b1 = a1 ^ 18'($urandom_range(1, 18'h3FFFF));
      exp_log = '{wa0(a0), wa1(a1), wa0(b0), wa1(b1)};
      cs0 = 1'b1; cs1 = 1'b1; addr0 = a0; addr1 = a1;
      for (int i = 0; i < 100 && !(ok0 && ok1); i++) tick();
      n_tests++;
      if (ok0 !== 1'b1 || ok1 !== 1'b1 || dout0 !== exp0(a0) || dout1 !== exp1(a1)) begin
         n_fail++;
         $display("FAIL arb_round1 ok=%b%b d0=%h d1=%h required 11 %h %h", ok0, ok1, dout0, dout1, exp0(a0), exp1(a1));
      end
      addr0 = b0; addr1 = b1;
      tick();
      for (int i = 0; i < 100 && !(ok0 && ok1); i++) tick();
      n_tests++;
      if (ok0 !== 1'b1 || ok1 !== 1'b1 || dout0 !== exp0(b0) || dout1 !== exp1(b1)) begin
         n_fail++;
         $display("FAIL arb_round2 ok=%b%b d0=%h d1=%h required 11 %h %h", ok0, ok1, dout0, dout1, exp0(b0), exp1(b1));
      end
      n_tests++;
      if (req_log.size() != 4) begin
         n_fail++; $display("FAIL arb_count got %0d requests required 4", req_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (req_log[i] !== exp_log[i]) begin
               n_fail++; $display("FAIL arb_order[%0d] addr=%h required %h", i, req_log[i], exp_log[i]);
            end
         end
      end
      n_tests++;
      if (unstable != 0) begin
         n_fail++; $display("FAIL arb_addr_stable violations=%0d required 0", unstable);
      end
      resp_en = 1'b0;
   endtask

   task automatic test_hit_and_abort();
      logic [15:0] x, y, z;
      do_reset();
      resp_en = 1'b1;
      x = 16'($urandom); y = x ^ 16'h0100; z = x ^ 16'h0200;
      cs0 = 1'b1; addr0 = x;
      for (int i = 0; i < 50 && !ok0; i++) tick();
      resp_en = 1'b0;
      n_tests++;
      if (ok0 !== 1'b1 || dout0 !== exp0(x)) begin
         n_fail++; $display("FAIL hit_first ok0=%b dout0=%h required 1 %h", ok0, dout0, exp0(x));
      end
      cs0 = 1'b0;
      tick();
      n_tests++;
      if (ok0 !== 1'b0) begin
         n_fail++; $display("FAIL hit_cs_drop ok0=%b required 0", ok0);
      end
      cs0 = 1'b1;
      tick();
      n_tests++;
      if (ok0 !== 1'b1 || dout0 !== exp0(x) || sdram_req !== 1'b0) begin
         n_fail++; $display("FAIL hit_again ok0=%b dout0=%h req=%b required 1 %h 0", ok0, dout0, sdram_req, exp0(x));
      end
      // move the address in the middle of a burst
      addr0 = y;
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      n_tests++;
      if (sdram_req !== 1'b1 || sdram_addr !== wa0(y)) begin
         n_fail++; $display("FAIL abort_issue req=%b addr=%h required 1 %h", sdram_req, sdram_addr, wa0(y));
      end
      m_ack = 1'b1; tick(); m_ack = 1'b0;
      addr0 = z;
      tick();
      m_dst = 1'b1; m_rdy = 1'b1; m_read = mem(wa0(y)); tick();
      m_dst = 1'b0; m_rdy = 1'b0;
      tick();
      n_tests++;
      if (ok0 !== 1'b0) begin
         n_fail++; $display("FAIL abort_ok ok0=%b required 0", ok0);
      end
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      n_tests++;
      if (sdram_req !== 1'b1 || sdram_addr !== wa0(z)) begin
         n_fail++; $display("FAIL abort_reissue req=%b addr=%h required 1 %h", sdram_req, sdram_addr, wa0(z));
      end
      resp_en = 1'b1;
      for (int i = 0; i < 50 && !ok0; i++) tick();
      resp_en = 1'b0;
      n_tests++;
      if (ok0 !== 1'b1 || dout0 !== exp0(z)) begin
         n_fail++; $display("FAIL abort_final ok0=%b dout0=%h required 1 %h", ok0, dout0, exp0(z));
      end
   endtask

   task automatic test_rdy_only();
      logic [15:0] p;
      do_reset();
      cs1 = 1'b1; addr1 = 18'($urandom);
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      m_ack = 1'b1; tick(); m_ack = 1'b0; tick();
      m_dst = 1'b1; m_read = 16'hBEEF; tick();
      m_dst = 1'b0; m_read = 16'hDEAD; tick();
      m_rdy = 1'b1; tick(); m_rdy = 1'b0;
      tick();
      n_tests++;
      if (ok1 !== 1'b1 || dout1 !== 32'h0000_BEEF) begin
         n_fail++; $display("FAIL rdy_one_word ok1=%b dout1=%h required 1 0000beef", ok1, dout1);
      end
      cs1 = 1'b0;
      p = 16'($urandom);
      cs0 = 1'b1; addr0 = p;
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      serve(16'hFFFF, 16'h0, 1'b0);
      tick();
      addr0 = p ^ 16'h0002;
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      m_ack = 1'b1; tick(); m_ack = 1'b0; tick();
      m_rdy = 1'b1; m_read = 16'h1357; tick(); m_rdy = 1'b0;
      tick();
      n_tests++;
      if (ok0 !== 1'b1 || dout0 !== 8'h00) begin
         n_fail++; $display("FAIL rdy_no_word ok0=%b dout0=%h required 1 00", ok0, dout0);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [15:0] w;
      do_reset();
      w = 16'($urandom);
      cs0 = 1'b1; addr0 = w;
      for (int i = 0; i < 8 && !sdram_req; i++) tick();
      m_ack = 1'b1; tick(); m_ack = 1'b0; tick();
      rst_n = 1'b0; cs0 = 1'b0;
      tick();
      rst_n = 1'b1;
      m_dst = 1'b1; m_rdy = 1'b1; m_read = 16'h7777; tick();
      m_dst = 1'b0; m_rdy = 1'b0;
      n_tests++;
      if (sdram_req !== 1'b0 || ok0 !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_idle req=%b ok0=%b required 0 0", sdram_req, ok0);
      end
      tick();
      cs0 = 1'b1;
      tick();
      n_tests++;
      if (ok0 !== 1'b0 || sdram_req !== 1'b1 || sdram_addr !== wa0(w)) begin
         n_fail++;
         $display("FAIL rst_mid_fresh ok0=%b req=%b addr=%h required 0 1 %h", ok0, sdram_req, sdram_addr, wa0(w));
      end
      serve(16'hC3A5, 16'h0, 1'b0);
      tick();
      n_tests++;
      if (ok0 !== 1'b1 || dout0 !== (w[0] ? 8'hC3 : 8'hA5)) begin
         n_fail++; $display("FAIL rst_mid_refill ok0=%b dout0=%h required 1 %h", ok0, dout0, w[0] ? 8'hC3 : 8'hA5);
      end
   endtask

   task automatic test_random();
      bit c0, c1;
      do_reset();
      resp_en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         c0 = 1'($urandom_range(0, 1));
         c1 = c0 ? 1'($urandom_range(0, 1)) : 1'b1;
         cs0 = c0; cs1 = c1;
         addr0 = 16'($urandom_range(0, 7));
         addr1 = 18'($urandom_range(0, 7));
         tick();
         for (int i = 0; i < 200 && !((!c0 || ok0) && (!c1 || ok1)); i++) tick();
         n_tests++;
         if ((c0 && (ok0 !== 1'b1 || dout0 !== exp0(addr0))) || (c1 && (ok1 !== 1'b1 || dout1 !== exp1(addr1)))) begin
            n_fail++;
            $display("FAIL random[%0d] cs=%b%b ok=%b%b d0=%h d1=%h required %h %h",
                     n, c0, c1, ok0, ok1, dout0, dout1, exp0(addr0), exp1(addr1));
         end
      end
      resp_en = 1'b0;
   endtask

   initial begin
      cs0 = 1'b0; cs1 = 1'b0; addr0 = '0; addr1 = '0;
      m_ack = 1'b0; m_dst = 1'b0; m_rdy = 1'b0; m_read = '0;
      test_reset();
      test_byte_slot();
      test_word32_slot();
      test_arbitration();
      test_hit_and_abort();
      test_rdy_only();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
